// File: rtl/i2c_slave_rx_block.sv
// I2C target-side receiver: START/STOP detection, 7-bit address match with
// ACK, and a single-entry valid/ready holding register for received bytes.
module i2c_slave_rx_block #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       i2c_core_clock_i,
    input  logic       reset_bit_i,
    input  logic       enable_i,
    input  logic [6:0] slave_address_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_low_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic       start_det_o,
    output logic       stop_det_o,
    output logic       addr_match_o,
    output logic       overflow_o,
    output logic       busy_o
);

    localparam int unsigned CNT_W  = 3;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_DATA,
        ST_DATA_ACK,
        ST_IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_dly;
    logic                   sda_dly;

    logic scl_s;
    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic sda_rise;
    logic sda_fall;
    logic start_cond;
    logic stop_cond;

    state_t              state;
    state_t              state_n;
    logic [CNT_W-1:0]    bit_cnt;
    logic [CNT_W-1:0]    bit_cnt_n;
    logic [BYTE_W-1:0]   shift;
    logic [BYTE_W-1:0]   shift_n;
    logic                byte_full;
    logic                byte_full_n;
    logic                sda_low_n;
    logic [BYTE_W-1:0]   rx_data_n;
    logic                rx_valid_n;
    logic                start_n;
    logic                stop_n;
    logic                match_n;
    logic                ovf_n;
    logic                busy_n;
    logic                space;

    // Pad synchronizers plus one delay flop per line for edge detection.
    always_ff @(posedge i2c_core_clock_i or negedge reset_bit_i) begin
        if (!reset_bit_i) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_dly  <= 1'b1;
            sda_dly  <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_dly  <= scl_sync[SYNC_STAGES-1];
            sda_dly  <= sda_sync[SYNC_STAGES-1];
        end
    end

    // Line edges and bus conditions from the synchronized view.
    always_comb begin
        scl_s      = scl_sync[SYNC_STAGES-1];
        sda_s      = sda_sync[SYNC_STAGES-1];
        scl_rise   = scl_s & ~scl_dly;
        scl_fall   = ~scl_s & scl_dly;
        sda_rise   = sda_s & ~sda_dly;
        sda_fall   = ~sda_s & sda_dly;
        start_cond = sda_fall & scl_s;
        stop_cond  = sda_rise & scl_s;
    end

    // State, datapath and output registers.
    always_ff @(posedge i2c_core_clock_i or negedge reset_bit_i) begin
        if (!reset_bit_i) begin
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            shift        <= '0;
            byte_full    <= 1'b0;
            sda_low_o    <= 1'b0;
            rx_data_o    <= '0;
            rx_valid_o   <= 1'b0;
            start_det_o  <= 1'b0;
            stop_det_o   <= 1'b0;
            addr_match_o <= 1'b0;
            overflow_o   <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            state        <= state_n;
            bit_cnt      <= bit_cnt_n;
            shift        <= shift_n;
            byte_full    <= byte_full_n;
            sda_low_o    <= sda_low_n;
            rx_data_o    <= rx_data_n;
            rx_valid_o   <= rx_valid_n;
            start_det_o  <= start_n;
            stop_det_o   <= stop_n;
            addr_match_o <= match_n;
            overflow_o   <= ovf_n;
            busy_o       <= busy_n;
        end
    end

    // Next-state and next-output logic; bus conditions override SCL edge work.
    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shift_n     = shift;
        byte_full_n = byte_full;
        sda_low_n   = sda_low_o;
        rx_data_n   = rx_data_o;
        rx_valid_n  = rx_valid_o & ~rx_ready_i;
        start_n     = 1'b0;
        stop_n      = 1'b0;
        match_n     = 1'b0;
        ovf_n       = 1'b0;
        space       = ~rx_valid_o | rx_ready_i;

        if (!enable_i) begin
            state_n     = ST_IDLE;
            bit_cnt_n   = '0;
            byte_full_n = 1'b0;
            sda_low_n   = 1'b0;
            rx_valid_n  = rx_valid_o;
        end else if (start_cond) begin
            state_n     = ST_ADDR;
            bit_cnt_n   = '0;
            byte_full_n = 1'b0;
            sda_low_n   = 1'b0;
            start_n     = 1'b1;
        end else if (stop_cond) begin
            state_n     = ST_IDLE;
            bit_cnt_n   = '0;
            byte_full_n = 1'b0;
            sda_low_n   = 1'b0;
            stop_n      = 1'b1;
        end else begin
            case (state)
                ST_ADDR, ST_DATA: begin
                    if (scl_rise && !byte_full) begin
                        shift_n   = {shift[BYTE_W-2:0], sda_s};
                        bit_cnt_n = bit_cnt + CNT_W'(1);
                        if (bit_cnt == CNT_W'(7)) begin
                            byte_full_n = 1'b1;
                        end
                    end else if (scl_fall && byte_full) begin
                        byte_full_n = 1'b0;
                        bit_cnt_n   = '0;
                        if (state == ST_ADDR) begin
                            if (shift[7:1] == slave_address_i && !shift[0]) begin
                                state_n   = ST_ADDR_ACK;
                                sda_low_n = 1'b1;
                                match_n   = 1'b1;
                            end else begin
                                state_n   = ST_IGNORE;
                                sda_low_n = 1'b0;
                            end
                        end else begin
                            state_n = ST_DATA_ACK;
                            if (space) begin
                                rx_data_n  = shift;
                                rx_valid_n = 1'b1;
                                sda_low_n  = 1'b1;
                            end else begin
                                sda_low_n  = 1'b0;
                                ovf_n      = 1'b1;
                            end
                        end
                    end
                end
                ST_ADDR_ACK, ST_DATA_ACK: begin
                    if (scl_fall) begin
                        state_n   = ST_DATA;
                        bit_cnt_n = '0;
                        sda_low_n = 1'b0;
                    end
                end
                ST_IGNORE: begin
                    sda_low_n = 1'b0;
                end
                default: begin
                    sda_low_n = 1'b0;
                end
            endcase
        end

        busy_n = (state_n != ST_IDLE);
    end

endmodule

// File: tb/tb_i2c_slave_rx_block.sv
// Directed bench for i2c_slave_rx_block: drives an open-drain bus model,
// checks every cycle against a bit-level protocol model, plus literal checks.
module tb_i2c_slave_rx_block;

    localparam int unsigned S = 2;
    localparam int H = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic [6:0] addr = 7'h5A;
    logic       scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       ready = 1'b0;
    logic       sda_line;
    logic       sda_low;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       start_det, stop_det, addr_match, overflow, busy;

    assign sda_line = m_sda & ~sda_low;

    i2c_slave_rx_block #(.SYNC_STAGES(S)) dut (
        .i2c_core_clock_i(clk),
        .reset_bit_i     (rst_n),
        .enable_i        (en),
        .slave_address_i (addr),
        .scl_i           (scl),
        .sda_i           (sda_line),
        .sda_low_o       (sda_low),
        .rx_data_o       (rx_data),
        .rx_valid_o      (rx_valid),
        .rx_ready_i      (ready),
        .start_det_o     (start_det),
        .stop_det_o      (stop_det),
        .addr_match_o    (addr_match),
        .overflow_o      (overflow),
        .busy_o          (busy)
    );

    initial forever #5 clk = ~clk;

    int total = 0;
    int passed = 0;
    int n_start = 0, n_stop = 0, n_match = 0, n_ovf = 0, n_sdalow = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- protocol model ----------------
    bit   h_scl [S+2];
    bit   h_sda [S+2];
    bit   c_scl, c_sda, c_en, c_ready;
    int   c_addr;
    bit   m_active = 0, m_ign = 0, m_addrd = 0, m_ack = 0;
    int   m_bits = 0, m_byte = 0;
    logic m_sda_low = 0, m_valid = 0, m_start = 0, m_stop = 0, m_match = 0, m_ovf = 0, m_busy = 0;
    logic [7:0] m_data = 8'h00;

    initial begin
        for (int k = 0; k < S + 2; k++) begin
            h_scl[k] = 1'b1;
            h_sda[k] = 1'b1;
        end
        forever begin
            @(negedge clk);
            #1;
            c_scl = scl; c_sda = sda_line; c_en = en; c_ready = ready; c_addr = int'(addr);
            @(posedge clk);
            if (!rst_n) begin
                for (int k = 0; k < S + 2; k++) begin
                    h_scl[k] = 1'b1;
                    h_sda[k] = 1'b1;
                end
                m_active = 0; m_ign = 0; m_addrd = 0; m_ack = 0; m_bits = 0; m_byte = 0;
                m_sda_low = 0; m_valid = 0; m_data = 8'h00; m_busy = 0;
                m_start = 0; m_stop = 0; m_match = 0; m_ovf = 0;
            end else begin
                bit s_scl, d_scl, s_sda, d_sda;
                for (int k = S + 1; k > 0; k--) begin
                    h_scl[k] = h_scl[k-1];
                    h_sda[k] = h_sda[k-1];
                end
                h_scl[0] = c_scl;
                h_sda[0] = c_sda;
                s_scl = h_scl[S]; d_scl = h_scl[S+1];
                s_sda = h_sda[S]; d_sda = h_sda[S+1];
                m_start = 0; m_stop = 0; m_match = 0; m_ovf = 0;
                if (!c_en) begin
                    m_active = 0; m_ack = 0; m_sda_low = 0; m_bits = 0;
                end else begin
                    if (c_ready) m_valid = 0;
                    if (!s_sda && d_sda && s_scl) begin
                        m_active = 1; m_ign = 0; m_addrd = 0; m_ack = 0;
                        m_bits = 0; m_byte = 0; m_sda_low = 0; m_start = 1;
                    end else if (s_sda && !d_sda && s_scl) begin
                        m_active = 0; m_ign = 0; m_ack = 0; m_bits = 0;
                        m_sda_low = 0; m_stop = 1;
                    end else if (m_active && !m_ign) begin
                        if (m_ack) begin
                            if (!s_scl && d_scl) begin
                                m_ack = 0; m_sda_low = 0; m_bits = 0; m_byte = 0;
                            end
                        end else if (s_scl && !d_scl && m_bits < 8) begin
                            m_byte = (m_byte * 2 + int'(s_sda)) % 256;
                            m_bits++;
                        end else if (!s_scl && d_scl && m_bits == 8) begin
                            if (!m_addrd) begin
                                if (m_byte == c_addr * 2) begin
                                    m_match = 1; m_sda_low = 1; m_ack = 1; m_addrd = 1;
                                end else begin
                                    m_ign = 1; m_sda_low = 0;
                                end
                            end else begin
                                m_ack = 1;
                                if (!m_valid) begin
                                    m_data = 8'(m_byte); m_valid = 1; m_sda_low = 1;
                                end else begin
                                    m_ovf = 1; m_sda_low = 0;
                                end
                            end
                        end
                    end
                end
                m_busy = m_active;
            end
        end
    end

    // Per-cycle comparison against the model, plus pulse tallies.
    initial forever begin
        @(posedge clk);
        #1;
        chk("cyc sda_low_o",    sda_low,    m_sda_low);
        chk("cyc rx_data_o",    rx_data,    m_data);
        chk("cyc rx_valid_o",   rx_valid,   m_valid);
        chk("cyc start_det_o",  start_det,  m_start);
        chk("cyc stop_det_o",   stop_det,   m_stop);
        chk("cyc addr_match_o", addr_match, m_match);
        chk("cyc overflow_o",   overflow,   m_ovf);
        chk("cyc busy_o",       busy,       m_busy);
        if (start_det)  n_start++;
        if (stop_det)   n_stop++;
        if (addr_match) n_match++;
        if (overflow)   n_ovf++;
        if (sda_low)    n_sdalow++;
    end

    // ---------------- bus master tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start;
        if (scl == 1'b0) begin
            cyc(3); m_sda = 1'b1; cyc(H - 3); scl = 1'b1; cyc(H);
        end else begin
            cyc(H);
        end
        m_sda = 1'b0; cyc(H); scl = 1'b0;
    endtask

    task automatic bus_stop;
        cyc(3); m_sda = 1'b0; cyc(H - 3); scl = 1'b1; cyc(H); m_sda = 1'b1; cyc(H);
    endtask

    task automatic send_bit(input bit b, output bit line);
        cyc(3); m_sda = b; cyc(H - 3); scl = 1'b1;
        cyc(H / 2); line = sda_line; cyc(H - H / 2); scl = 1'b0;
    endtask

    task automatic bits8(input logic [7:0] b);
        bit d;
        for (int i = 7; i >= 0; i--) send_bit(b[i], d);
    endtask

    task automatic ack_clk(input bit pulse, output bit ack);
        cyc(2); if (pulse) ready = 1'b1;
        cyc(1); if (pulse) ready = 1'b0;
        m_sda = 1'b1; cyc(H - 3); scl = 1'b1;
        cyc(H / 2); ack = sda_line; cyc(H - H / 2); scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit pulse, output bit ack);
        bits8(b);
        ack_clk(pulse, ack);
    endtask

    task automatic consume;
        ready = 1'b1; cyc(1); ready = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit a, d;
        int s_start, s_stop, s_match, s_ovf, s_low;

        cyc(3);
        chk("reset sda_low_o", sda_low, 0);
        chk("reset rx_data_o", rx_data, 0);
        chk("reset rx_valid_o", rx_valid, 0);
        chk("reset busy_o", busy, 0);
        rst_n = 1'b1;
        cyc(4);

        // Address match and one data byte.
        s_start = n_start; s_stop = n_stop; s_match = n_match;
        bus_start;
        send_byte(8'hB4, 1'b0, a); chk("t1 addr ack", a, 0);
        send_byte(8'h3C, 1'b0, a); chk("t1 data ack", a, 0);
        bus_stop;
        chk("t1 rx_data", rx_data, 8'h3C);
        chk("t1 rx_valid", rx_valid, 1);
        chk("t1 match count", n_match - s_match, 1);
        chk("t1 start count", n_start - s_start, 1);
        chk("t1 stop count", n_stop - s_stop, 1);
        chk("t1 busy idle", busy, 0);
        consume;
        chk("consume valid", rx_valid, 0);

        // Wrong address, then a read request.
        s_low = n_sdalow; s_match = n_match;
        bus_start;
        send_byte(8'hB6, 1'b0, a); chk("t2 wrong addr nack", a, 1);
        send_byte(8'h3C, 1'b0, a); chk("t2 ignored data nack", a, 1);
        chk("t2 ignore busy", busy, 1);
        bus_stop;
        chk("t2 busy after stop", busy, 0);
        bus_start;
        send_byte(8'hB5, 1'b0, a); chk("t2 read nack", a, 1);
        send_byte(8'h3C, 1'b0, a); chk("t2 read data nack", a, 1);
        bus_stop;
        chk("t2 sda_low cycles", n_sdalow - s_low, 0);
        chk("t2 rx_valid", rx_valid, 0);
        chk("t2 match count", n_match - s_match, 0);

        // Overflow, then a full register freed at the decision edge.
        s_ovf = n_ovf;
        bus_start;
        send_byte(8'hB4, 1'b0, a); chk("t3 addr ack", a, 0);
        send_byte(8'h11, 1'b0, a); chk("t3 first ack", a, 0);
        send_byte(8'h22, 1'b0, a); chk("t3 second nack", a, 1);
        bus_stop;
        chk("t3 overflow count", n_ovf - s_ovf, 1);
        chk("t3 rx_data held", rx_data, 8'h11);
        chk("t3 rx_valid", rx_valid, 1);
        consume;
        bus_start;
        send_byte(8'hB4, 1'b0, a); chk("t3b addr ack", a, 0);
        send_byte(8'h11, 1'b0, a); chk("t3b first ack", a, 0);
        send_byte(8'h22, 1'b1, a); chk("t3b second ack", a, 0);
        bus_stop;
        chk("t3b rx_data", rx_data, 8'h22);
        chk("t3b rx_valid", rx_valid, 1);
        chk("t3b overflow count", n_ovf - s_ovf, 1);
        consume;

        // Repeated START after four data bits.
        s_start = n_start; s_match = n_match;
        bus_start;
        send_byte(8'hB4, 1'b0, a); chk("t4 addr ack", a, 0);
        send_bit(1'b1, d); send_bit(1'b0, d); send_bit(1'b1, d); send_bit(1'b0, d);
        bus_start;
        send_byte(8'hB4, 1'b0, a); chk("t4 readdr ack", a, 0);
        send_byte(8'h5B, 1'b0, a); chk("t4 data ack", a, 0);
        bus_stop;
        chk("t4 start count", n_start - s_start, 2);
        chk("t4 match count", n_match - s_match, 2);
        chk("t4 rx_data", rx_data, 8'h5B);
        chk("t4 rx_valid", rx_valid, 1);

        // Reset while the address ACK is driven.
        bus_start;
        bits8(8'hB4);
        cyc(3); m_sda = 1'b1; cyc(1);
        chk("t5 ack before reset", sda_low, 1);
        rst_n = 1'b0;
        #1;
        chk("t5 sda_low in reset", sda_low, 0);
        chk("t5 rx_valid in reset", rx_valid, 0);
        chk("t5 rx_data in reset", rx_data, 0);
        chk("t5 busy in reset", busy, 0);
        cyc(2); rst_n = 1'b1;
        cyc(H - 6); scl = 1'b1; cyc(H); scl = 1'b0;
        s_match = n_match;
        send_byte(8'hB4, 1'b0, a); chk("t5 no start nack", a, 1);
        chk("t5 match count", n_match - s_match, 0);
        bus_stop;

        // Disable during the address ACK with a full holding register.
        bus_start;
        send_byte(8'hB4, 1'b0, a); chk("t6 addr ack", a, 0);
        send_byte(8'h66, 1'b0, a); chk("t6 data ack", a, 0);
        bus_start;
        bits8(8'hB4);
        cyc(3); m_sda = 1'b1; cyc(1);
        chk("t6 ack before disable", sda_low, 1);
        en = 1'b0;
        s_start = n_start; s_stop = n_stop; s_match = n_match; s_ovf = n_ovf;
        cyc(1);
        chk("t6 sda released", sda_low, 0);
        chk("t6 busy disabled", busy, 0);
        cyc(H - 5); scl = 1'b1; cyc(H); scl = 1'b0;
        send_byte(8'h12, 1'b0, a); chk("t6 disabled nack", a, 1);
        bus_stop;
        chk("t6 pulses suppressed",
            (n_start - s_start) + (n_stop - s_stop) + (n_match - s_match) + (n_ovf - s_ovf), 0);
        chk("t6 rx_data kept", rx_data, 8'h66);
        chk("t6 rx_valid kept", rx_valid, 1);
        en = 1'b1;
        cyc(4);
        consume;
        cyc(4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/i2c_slave_rx_block.md
# i2c_slave_rx_block

I2C target-side (slave) receiver running on the I2C core clock. It samples SCL/SDA from the pads and detects START, repeated START and STOP conditions. It matches the 7-bit address, acknowledges master-write transfers, and hands each received data byte to the CPU through a single-entry valid/ready holding register. It is the responder counterpart of the master SCL generator and is used for loopback and slave-mode operation.

## Interface
- SYNC_STAGES, 2, number of synchronizer flops on scl_i and sda_i (must be ≥2).
- i2c_core_clock_i  input  1  I2C core clock; all logic on its rising edge.
- reset_bit_i  input  1  reset from CPU, asynchronous, active-low.
- enable_i  input  1  1 = block active; 0 = forced IDLE, SDA released.
- slave_address_i  input  7  own 7-bit address, sampled when the address byte completes.
- scl_i  input  1  SCL pad input, asynchronous.
- sda_i  input  1  SDA pad input, asynchronous.
- sda_low_o  output  1  1 = pull SDA low (open-drain enable); 0 = release.
- rx_data_o  output  8  holding register, valid while rx_valid_o=1.
- rx_valid_o  output  1  holding register full.
- rx_ready_i  input  1  CPU consumes the byte on a clock edge where rx_valid_o=1.
- start_det_o  output  1  one-cycle pulse on START or repeated START.
- stop_det_o  output  1  one-cycle pulse on STOP.
- addr_match_o  output  1  one-cycle pulse when the address matches with R/W=0.
- overflow_o  output  1  one-cycle pulse when a byte is NACKed because the holding register is full.
- busy_o  output  1  1 when state ≠ IDLE.

## Operation
- Synchronizer: SYNC_STAGES flops plus one delay flop per line; all flops reset to 1.
  - scl_rise/scl_fall and sda_rise/sda_fall are derived from the last synchronizer stage versus the delay flop.
- START: sda_fall while synchronized SCL=1. STOP: sda_rise while synchronized SCL=1. Both are valid in any state, including mid-byte and mid-ACK.
  - START: go to ADDR, bit counter=0, release SDA, pulse start_det_o.
  - STOP: go to IDLE, release SDA, pulse stop_det_o.
  - If START/STOP coincides with an SCL edge in the same cycle, the START/STOP wins.
- Shift register: 8 bits, MSB first. Data is sampled on scl_rise. A 3-bit counter counts 0..7.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits. On the scl_fall after the 8th bit, if shift[7:1]==slave_address_i and shift[0]==0, go to ADDR_ACK with sda_low_o=1 and pulse addr_match_o. Otherwise go to IGNORE with SDA released.
  - ADDR_ACK: hold SDA low through the 9th clock. On the next scl_fall, release SDA and go to DATA with counter=0.
  - DATA: shift 8 bits. On the scl_fall after the 8th bit, space = ~rx_valid_o | rx_ready_i.
    - space=1: load rx_data_o, rx_valid_o=1, sda_low_o=1 (ACK).
    - space=0: byte dropped, SDA released (NACK), pulse overflow_o.
    - Either way, go to DATA_ACK.
  - DATA_ACK: on the next scl_fall, release SDA and go to DATA with counter=0.
  - IGNORE: SDA released. Leave only on START or STOP.
- Read requests (R/W=1) are not supported. They are not acknowledged and the block enters IGNORE.
- Holding register: rx_valid_o clears on an edge with rx_ready_i=1 unless a new byte loads in the same edge, in which case it stays 1 with the new data.
- enable_i=0: state is IDLE, sda_low_o=0 and pulses are suppressed. The synchronizers keep running, and rx_data_o/rx_valid_o hold their values.

## Timing
- Reset values: sda_low_o=0, rx_data_o=0, rx_valid_o=0, start_det_o=0, stop_det_o=0, addr_match_o=0, overflow_o=0, busy_o=0, state=IDLE, counter=0.
- Reset mid-transfer aborts immediately (asynchronous) and releases SDA. The bus must see a fresh START before the block responds again.
- Pad-to-detect latency: SYNC_STAGES+1 core cycles. All outputs are registered.
  - sda_low_o changes 1 cycle after the detected scl_fall.
  - Pulses are exactly 1 cycle wide.
- Bus requirements:
  - SCL high and low phases each ≥ SYNC_STAGES+2 core cycles, i.e. master prescaler ≥4 with the default setting.
  - Master SDA changes ≥2 core cycles after SCL fall.
- ACK drive window: from scl_fall of the 8th bit + 1 cycle to scl_fall of the 9th bit + 1 cycle.
- No clock stretching: SCL is never driven.

## Test plan
- Address match: slave_address_i=0x5A; master sends START, 0xB4, 0x3C, STOP. Required: ACK low on both 9th clocks; addr_match_o pulses once; rx_data_o=0x3C with rx_valid_o=1; start_det_o and stop_det_o each pulse once; busy_o returns to 0.
- Address mismatch and read: send 0xB6 (wrong address), then 0xB5 (R/W=1). Required: sda_low_o never asserts, no rx_valid_o, block stays in IGNORE until STOP.
- Overflow: with rx_ready_i=0, send 0x11 then 0x22. Required: 0x11 ACKed and held; 0x22 NACKed; overflow_o pulses once; rx_data_o stays 0x11. Repeat with rx_ready_i=1 at the second byte's decision edge: 0x22 is ACKed and loaded.
- Repeated START mid-byte: after 4 data bits, issue START and then 0xB4. Required: partial byte discarded, start_det_o pulses, new address ACKed.
- Reset mid-ACK: assert reset_bit_i while sda_low_o=1. Required: sda_low_o=0 immediately; all outputs at reset values; bytes without a new START are ignored.
- enable_i=0 during a transfer: SDA released within 1 cycle, busy_o=0, no pulses; rx_data_o/rx_valid_o retained.
